// File: rtl/prog_seq_generator_pkg.sv
// Shared types and default widths for the programmable serial pattern generator.
package prog_seq_generator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } seq_gen_state_t;

  localparam int DEF_SEQ_W = 5;
  localparam int DEF_REP_W = 4;
  localparam int DEF_GAP_W = 3;

endpackage

// File: rtl/prog_seq_generator_if.sv
// Control/handshake and serial-output bundle of the pattern generator.
interface prog_seq_generator_if #(
  parameter int SEQ_W = prog_seq_generator_pkg::DEF_SEQ_W,
  parameter int REP_W = prog_seq_generator_pkg::DEF_REP_W,
  parameter int GAP_W = prog_seq_generator_pkg::DEF_GAP_W
);

  logic [SEQ_W-1:0] init;
  logic [REP_W-1:0] repeat_n;
  logic [GAP_W-1:0] gap;
  logic             start;
  logic             abort;
  logic             ready;
  logic             dout;
  logic             dout_valid;
  logic             done;

  modport master (
    output init, repeat_n, gap, start, abort,
    input  ready, dout, dout_valid, done
  );

  modport slave (
    input  init, repeat_n, gap, start, abort,
    output ready, dout, dout_valid, done
  );

endinterface

// File: rtl/prog_seq_generator_piso.sv
// Parallel-load, shift-left register; msb is the bit that will be sent next.
module prog_seq_generator_piso #(
  parameter int SEQ_W = prog_seq_generator_pkg::DEF_SEQ_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic             shift,
  input  logic [SEQ_W-1:0] din,
  output logic             msb
);

  logic [SEQ_W-1:0] sr_reg;
  logic [SEQ_W-1:0] sr_next;

  // Shift network: each stage takes its lower neighbour, LSB fills with 0.
  genvar gi;
  generate
    for (gi = 1; gi < SEQ_W; gi++) begin : g_shift
      assign sr_next[gi] = load ? din[gi] : (shift ? sr_reg[gi-1] : sr_reg[gi]);
    end
  endgenerate
  assign sr_next[0] = load ? din[0] : (shift ? 1'b0 : sr_reg[0]);

  always_ff @(posedge clk) begin
    if (!resetn) sr_reg <= '0;
    else         sr_reg <= sr_next;
  end

  assign msb = sr_reg[SEQ_W-1];

endmodule

// File: rtl/prog_seq_generator.sv
// Serialises a latched pattern MSB first, repeat_n+1 times, with gap idle cycles between copies.
module prog_seq_generator
  import prog_seq_generator_pkg::*;
#(
  parameter int SEQ_W = DEF_SEQ_W,
  parameter int REP_W = DEF_REP_W,
  parameter int GAP_W = DEF_GAP_W
) (
  input logic                 clk,
  input logic                 resetn,
  prog_seq_generator_if.slave bus
);

  localparam int IDX_W = (SEQ_W > 2) ? $clog2(SEQ_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEQ_W - 1);

  seq_gen_state_t   state_reg, state_next;
  logic [IDX_W-1:0] bit_idx_reg, bit_idx_next;
  logic [REP_W-1:0] rep_cnt_reg, rep_cnt_next;
  logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
  logic [GAP_W-1:0] gap_len_reg, gap_len_next;
  logic [SEQ_W-1:0] pat_reg, pat_next;
  logic             dout_reg, dout_next;
  logic             valid_reg, valid_next;
  logic             done_reg, done_next;

  logic             piso_load;
  logic             piso_shift;
  logic [SEQ_W-1:0] piso_din;
  logic             piso_msb;

  // dout is driven directly with the first bit of a copy, so the shifter is
  // loaded pre-shifted and always presents the following bit on msb.
  prog_seq_generator_piso #(.SEQ_W(SEQ_W)) u_piso (
    .clk    (clk),
    .resetn (resetn),
    .load   (piso_load),
    .shift  (piso_shift),
    .din    (piso_din),
    .msb    (piso_msb)
  );

  always_comb begin
    state_next   = state_reg;
    bit_idx_next = bit_idx_reg;
    rep_cnt_next = rep_cnt_reg;
    gap_cnt_next = gap_cnt_reg;
    gap_len_next = gap_len_reg;
    pat_next     = pat_reg;
    dout_next    = 1'b0;
    valid_next   = 1'b0;
    done_next    = 1'b0;
    piso_load    = 1'b0;
    piso_shift   = 1'b0;
    piso_din     = {pat_reg[SEQ_W-2:0], 1'b0};

    case (state_reg)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_next   = SEND;
          pat_next     = bus.init;
          rep_cnt_next = bus.repeat_n;
          gap_len_next = bus.gap;
          bit_idx_next = LAST_IDX;
          dout_next    = bus.init[SEQ_W-1];
          valid_next   = 1'b1;
          piso_load    = 1'b1;
          piso_din     = {bus.init[SEQ_W-2:0], 1'b0};
        end
      end

      SEND: begin
        if (bit_idx_reg != '0) begin
          bit_idx_next = bit_idx_reg - 1'b1;
          dout_next    = piso_msb;
          valid_next   = 1'b1;
          piso_shift   = 1'b1;
        end else if (rep_cnt_reg == '0) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          rep_cnt_next = rep_cnt_reg - 1'b1;
          if (gap_len_reg == '0) begin
            bit_idx_next = LAST_IDX;
            dout_next    = pat_reg[SEQ_W-1];
            valid_next   = 1'b1;
            piso_load    = 1'b1;
          end else begin
            state_next   = GAP;
            gap_cnt_next = gap_len_reg;
          end
        end
      end

      GAP: begin
        // gap_cnt holds the idle cycles left including the current one.
        if (gap_cnt_reg <= 1) begin
          state_next   = SEND;
          gap_cnt_next = '0;
          bit_idx_next = LAST_IDX;
          dout_next    = pat_reg[SEQ_W-1];
          valid_next   = 1'b1;
          piso_load    = 1'b1;
        end else begin
          gap_cnt_next = gap_cnt_reg - 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase

    if (bus.abort) begin
      state_next = IDLE;
      dout_next  = 1'b0;
      valid_next = 1'b0;
      done_next  = 1'b0;
      piso_load  = 1'b0;
      piso_shift = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg   <= IDLE;
      bit_idx_reg <= '0;
      rep_cnt_reg <= '0;
      gap_cnt_reg <= '0;
      gap_len_reg <= '0;
      pat_reg     <= '0;
      dout_reg    <= 1'b0;
      valid_reg   <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bit_idx_reg <= bit_idx_next;
      rep_cnt_reg <= rep_cnt_next;
      gap_cnt_reg <= gap_cnt_next;
      gap_len_reg <= gap_len_next;
      pat_reg     <= pat_next;
      dout_reg    <= dout_next;
      valid_reg   <= valid_next;
      done_reg    <= done_next;
    end
  end

  assign bus.ready      = (state_reg == IDLE);
  assign bus.dout       = dout_reg;
  assign bus.dout_valid = valid_reg;
  assign bus.done       = done_reg;

endmodule
